// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline.
//   WORD_W            datapath word width
//   NOP_INSTR         encoding used for pipeline bubbles
//   RESET_PC_DEFAULT  default PC after reset
//   if_id_t           IF/ID pipeline register contents
//   IF_ID_BUBBLE      IF/ID value representing an empty slot
//   word_align()      clears the two byte-offset bits of an address
package mips_pkg;

   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pcplus4;
      logic              valid;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pcplus4: '0, valid: 1'b0};

   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/flopenrc.sv
// Generic register with synchronous reset, synchronous clear and load enable.
// Priority: reset > clr > en.
//   clk    in  clock, posedge
//   reset  in  synchronous active-high reset, loads RST_VAL
//   en     in  load enable
//   clr    in  synchronous clear, loads CLR_VAL
//   d      in  next value (type T)
//   q      out registered value (type T)
module flopenrc
   import mips_pkg::*;
#(
   parameter type T       = logic [WORD_W-1:0],
   parameter T    RST_VAL = '0,
   parameter T    CLR_VAL = '0
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   input  T     d,
   output T     q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RST_VAL;
      end else if (clr) begin
         q <= CLR_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the pipelined MIPS core: holds the PC, addresses imem and
// registers the fetched word into the IF/ID register for decode.
// Optional feature macro: IF_PERF_CNT_EN (fetch/bubble performance counters;
// when undefined the counter outputs are constant zero).
//   clk, reset            clock and synchronous active-high reset
//   stall_f, stall_d      hold PC / hold IF/ID
//   flush_d               load a bubble into IF/ID
//   pcsrc_d, pcbranch_d   taken-branch redirect and target
//   jump_d, pcjump_d      jump redirect and target
//   imem_addr, imem_instr combinational instruction memory interface
//   pc_f                  current fetch PC
//   instr_d, pcplus4_d, valid_d   IF/ID register outputs
//   fetch_cnt, bubble_cnt performance counters
module fetch_stage
   import mips_pkg::*;
#(
   parameter int          IMEM_AW  = 8,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall_f,
   input  logic               stall_d,
   input  logic               flush_d,
   input  logic               pcsrc_d,
   input  logic [31:0]        pcbranch_d,
   input  logic               jump_d,
   input  logic [31:0]        pcjump_d,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_instr,
   output logic [31:0]        pc_f,
   output logic [31:0]        instr_d,
   output logic [31:0]        pcplus4_d,
   output logic               valid_d,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        bubble_cnt
);

   logic [31:0] pcplus4_f;
   logic [31:0] pc_next;
   logic        pc_en;
   if_id_t      if_id_next;
   if_id_t      if_id_q;

   assign pcplus4_f = pc_f + 32'd4;
   // Upper PC bits are dropped, so fetches wrap inside the ROM.
   assign imem_addr = pc_f[IMEM_AW-1:0];

   // A redirect must win over stall_f, otherwise a one-cycle redirect that
   // coincides with a stall would be lost.
   always_comb begin
      pc_next = pcplus4_f;
      if (jump_d) begin
         pc_next = word_align(pcjump_d);
      end else if (pcsrc_d) begin
         pc_next = word_align(pcbranch_d);
      end
   end

   assign pc_en = jump_d | pcsrc_d | ~stall_f;

   flopenrc #(
      .T       (logic [31:0]),
      .RST_VAL (RESET_PC),
      .CLR_VAL (RESET_PC)
   ) u_pc_reg (
      .clk   (clk),
      .reset (reset),
      .en    (pc_en),
      .clr   (1'b0),
      .d     (pc_next),
      .q     (pc_f)
   );

   // ---- IF -> ID boundary ----
   assign if_id_next = '{instr: imem_instr, pcplus4: pcplus4_f, valid: 1'b1};

   flopenrc #(
      .T       (if_id_t),
      .RST_VAL (IF_ID_BUBBLE),
      .CLR_VAL (IF_ID_BUBBLE)
   ) u_if_id_reg (
      .clk   (clk),
      .reset (reset),
      .en    (~stall_d),
      .clr   (flush_d),
      .d     (if_id_next),
      .q     (if_id_q)
   );

   assign instr_d   = if_id_q.instr;
   assign pcplus4_d = if_id_q.pcplus4;
   assign valid_d   = if_id_q.valid;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_q;
   logic [31:0] bubble_q;

   // Counters follow the IF/ID update priority: a flush counts as a bubble
   // even under stall_d, a stall holds both.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_q  <= '0;
         bubble_q <= '0;
      end else if (flush_d) begin
         bubble_q <= bubble_q + 32'd1;
      end else if (!stall_d) begin
         fetch_q  <= fetch_q + 32'd1;
      end
   end

   assign fetch_cnt  = fetch_q;
   assign bubble_cnt = bubble_q;
`else
   assign fetch_cnt  = 32'h0;
   assign bubble_cnt = 32'h0;
`endif

endmodule
